// File: rtl/dma_cmd_arbiter.sv
// Round-robin arbiter sharing one DMA write engine among N_REQ command requesters.
// One job is in flight at a time; completions return per requester with an error flag.
module dma_cmd_arbiter #(
    parameter int N_REQ          = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int ID_W          = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            s_req_valid,
    output logic [N_REQ-1:0]            s_req_ready,
    input  logic [N_REQ*ADDR_WIDTH-1:0] s_req_addr,
    input  logic [N_REQ*32-1:0]         s_req_len,
    output logic [N_REQ-1:0]            s_cpl_valid,
    output logic                        s_cpl_err,
    output logic                        o_dma_start,
    output logic [ADDR_WIDTH-1:0]       o_dma_base_addr,
    output logic [31:0]                 o_dma_total_len,
    output logic                        o_dma_abort,
    input  logic                        i_dma_done,
    input  logic                        i_dma_error,
    output logic                        o_busy,
    output logic [ID_W-1:0]             o_active_id
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        CPL   = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ID_W-1:0]    rr_ptr;
    logic [TMR_W-1:0]   timer;

    logic [N_REQ-1:0]   vld_rot;
    logic               grant_found;
    logic [ID_W-1:0]    grant_off;
    logic [ID_W:0]      grant_sum;
    logic [ID_W-1:0]    grant_id;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [31:0]        sel_len;
    logic               cmd_bad;
    logic               accept;

    logic               start_d;
    logic               abort_d;
    logic               cpl_d;
    logic               err_d;
    logic [ID_W-1:0]    cpl_id;
    logic [N_REQ-1:0]   cpl_oh;

    // Rotate valids so rr_ptr sits at bit 0; the lowest set bit is the winner offset.
    always_comb begin
        vld_rot     = N_REQ'({s_req_valid, s_req_valid} >> rr_ptr);
        grant_found = 1'b0;
        grant_off   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (vld_rot[i]) begin
                grant_found = 1'b1;
                grant_off   = ID_W'(i);
            end
        end
        grant_sum = {1'b0, rr_ptr} + {1'b0, grant_off};
        if (grant_sum >= (ID_W+1)'(N_REQ)) begin
            grant_sum = grant_sum - (ID_W+1)'(N_REQ);
        end
        grant_id = grant_sum[ID_W-1:0];
    end

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                sel_addr = s_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = s_req_len[k*32 +: 32];
            end
        end
        cmd_bad = (sel_len == 32'd0) || (sel_len[1:0] != 2'b00) || (sel_addr[1:0] != 2'b00);
    end

    assign accept = (state_q == IDLE) && grant_found;

    // Ready is gated by rst_n so no handshake can complete on a reset edge.
    always_comb begin
        s_req_ready = '0;
        if (rst_n && accept) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (grant_id == ID_W'(k)) begin
                    s_req_ready[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        abort_d = 1'b0;
        cpl_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    if (cmd_bad) begin
                        state_d = CPL;
                        cpl_d   = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        start_d = 1'b1;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (i_dma_error) begin
                    state_d = CPL;
                    cpl_d   = 1'b1;
                    err_d   = 1'b1;
                end else if (i_dma_done) begin
                    state_d = CPL;
                    cpl_d   = 1'b1;
                end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = CPL;
                    cpl_d   = 1'b1;
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                end
            end
            CPL:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A rejected command completes straight from IDLE, before o_active_id is latched.
    always_comb begin
        cpl_id = (state_q == IDLE) ? grant_id : o_active_id;
        cpl_oh = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (cpl_d && (cpl_id == ID_W'(k))) begin
                cpl_oh[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            rr_ptr          <= '0;
            timer           <= '0;
            s_cpl_valid     <= '0;
            s_cpl_err       <= 1'b0;
            o_dma_start     <= 1'b0;
            o_dma_abort     <= 1'b0;
            o_busy          <= 1'b0;
            o_active_id     <= '0;
            o_dma_base_addr <= '0;
            o_dma_total_len <= '0;
        end else begin
            state_q     <= state_d;
            s_cpl_valid <= cpl_oh;
            s_cpl_err   <= err_d;
            o_dma_start <= start_d;
            o_dma_abort <= abort_d;
            o_busy      <= (state_d != IDLE);
            if (accept) begin
                o_active_id     <= grant_id;
                o_dma_base_addr <= sel_addr;
                o_dma_total_len <= sel_len;
            end
            // The ISSUE cycle counts toward the timeout, so abort lands TIMEOUT_CYCLES after start.
            if (state_q == ISSUE || state_q == WAIT) begin
                timer <= timer + TMR_W'(1);
            end else begin
                timer <= '0;
            end
            if (state_q == CPL) begin
                rr_ptr <= (o_active_id == ID_W'(N_REQ - 1)) ? '0 : o_active_id + ID_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dma_cmd_arbiter.sv
// Directed bench for dma_cmd_arbiter: 4 requesters, 16-cycle watchdog.
module tb_dma_cmd_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   s_req_valid;
    logic [3:0]   s_req_ready;
    logic [127:0] s_req_addr;
    logic [127:0] s_req_len;
    logic [3:0]   s_cpl_valid;
    logic         s_cpl_err;
    logic         o_dma_start;
    logic [31:0]  o_dma_base_addr;
    logic [31:0]  o_dma_total_len;
    logic         o_dma_abort;
    logic         i_dma_done;
    logic         i_dma_error;
    logic         o_busy;
    logic [1:0]   o_active_id;

    int n_cmp = 0;
    int n_err = 0;

    dma_cmd_arbiter #(
        .N_REQ(4),
        .ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_req_valid(s_req_valid),
        .s_req_ready(s_req_ready),
        .s_req_addr(s_req_addr),
        .s_req_len(s_req_len),
        .s_cpl_valid(s_cpl_valid),
        .s_cpl_err(s_cpl_err),
        .o_dma_start(o_dma_start),
        .o_dma_base_addr(o_dma_base_addr),
        .o_dma_total_len(o_dma_total_len),
        .o_dma_abort(o_dma_abort),
        .i_dma_done(i_dma_done),
        .i_dma_error(i_dma_error),
        .o_busy(o_busy),
        .o_active_id(o_active_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] addr, input logic [31:0] len);
        s_req_addr[k*32 +: 32] = addr;
        s_req_len[k*32 +: 32]  = len;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        s_req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) set_req(k, 32'h0000_1000, 32'd16);
        step();
        step();
        n_cmp++;
        if (s_req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ready: got %b expected 0000", s_req_ready);
        end
        n_cmp++;
        if ({o_busy, o_dma_start, o_dma_abort, s_cpl_err, s_cpl_valid, o_active_id} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: busy=%b start=%b abort=%b err=%b cpl=%b id=%0d expected all 0",
                     o_busy, o_dma_start, o_dma_abort, s_cpl_err, s_cpl_valid, o_active_id);
        end
        n_cmp++;
        if (o_dma_base_addr !== 32'd0 || o_dma_total_len !== 32'd0) begin
            n_err++;
            $display("FAIL reset_data: base=%h len=%h expected 0 and 0", o_dma_base_addr, o_dma_total_len);
        end
        s_req_valid = 4'b0000;
        rst_n       = 1'b1;
        step();
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_busy: got %b expected 0", o_busy);
        end
    endtask

    task automatic test_single();
        set_req(0, 32'h1000_0000, 32'd1024);
        s_req_valid = 4'b0001;
        #1;
        n_cmp++;
        if (s_req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL single_ready: got %b expected 0001", s_req_ready);
        end
        step();
        s_req_valid = 4'b0000;
        n_cmp++;
        if (o_dma_start !== 1'b1 || o_dma_base_addr !== 32'h1000_0000 || o_dma_total_len !== 32'd1024
            || o_active_id !== 2'd0 || o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_start: start=%b base=%h len=%0d id=%0d busy=%b expected 1 10000000 1024 0 1",
                     o_dma_start, o_dma_base_addr, o_dma_total_len, o_active_id, o_busy);
        end
        step();
        n_cmp++;
        if (o_dma_start !== 1'b0) begin
            n_err++;
            $display("FAIL single_start_width: got %b expected 0", o_dma_start);
        end
        repeat (10) step();
        i_dma_done = 1'b1;
        step();
        i_dma_done = 1'b0;
        n_cmp++;
        if (s_cpl_valid !== 4'b0001 || s_cpl_err !== 1'b0 || o_dma_abort !== 1'b0) begin
            n_err++;
            $display("FAIL single_cpl: cpl=%b err=%b abort=%b expected 0001 0 0", s_cpl_valid, s_cpl_err, o_dma_abort);
        end
        step();
        n_cmp++;
        if (s_cpl_valid !== 4'b0000 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_after: cpl=%b busy=%b expected 0000 0", s_cpl_valid, o_busy);
        end
    endtask

    task automatic test_fairness();
        int         order [6] = '{0, 1, 2, 3, 0, 1};
        int         e;
        logic [3:0] exp_oh;
        logic [31:0] exp_addr;
        do_reset();
        for (int k = 0; k < 4; k++) set_req(k, 32'h4000_0000 + 32'(k) * 32'h100, 32'd64 * 32'(k + 1));
        s_req_valid = 4'b1111;
        for (int j = 0; j < 6; j++) begin
            e        = order[j];
            exp_oh   = 4'b0001 << e;
            exp_addr = 32'h4000_0000 + 32'(e) * 32'h100;
            #1;
            n_cmp++;
            if (s_req_ready !== exp_oh) begin
                n_err++;
                $display("FAIL fair_ready[%0d]: got %b expected %b", j, s_req_ready, exp_oh);
            end
            step();
            n_cmp++;
            if (o_dma_start !== 1'b1 || o_active_id !== 2'(e) || o_dma_base_addr !== exp_addr) begin
                n_err++;
                $display("FAIL fair_start[%0d]: start=%b id=%0d base=%h expected 1 %0d %h",
                         j, o_dma_start, o_active_id, o_dma_base_addr, e, exp_addr);
            end
            repeat (3) step();
            i_dma_done = 1'b1;
            step();
            i_dma_done = 1'b0;
            n_cmp++;
            if (s_cpl_valid !== exp_oh || s_cpl_err !== 1'b0) begin
                n_err++;
                $display("FAIL fair_cpl[%0d]: cpl=%b err=%b expected %b 0", j, s_cpl_valid, s_cpl_err, exp_oh);
            end
            step();
        end
        s_req_valid = 4'b0000;
    endtask

    task automatic test_validation();
        logic [31:0] v_addr [3] = '{32'h2000_0000, 32'h2000_0002, 32'h2000_0000};
        logic [31:0] v_len  [3] = '{32'd1022, 32'd1024, 32'd0};
        for (int j = 0; j < 3; j++) begin
            set_req(2, v_addr[j], v_len[j]);
            s_req_valid = 4'b0100;
            #1;
            n_cmp++;
            if (s_req_ready !== 4'b0100) begin
                n_err++;
                $display("FAIL val_ready[%0d]: got %b expected 0100", j, s_req_ready);
            end
            step();
            n_cmp++;
            if (s_cpl_valid !== 4'b0100 || s_cpl_err !== 1'b1 || o_dma_start !== 1'b0
                || o_dma_total_len !== v_len[j]) begin
                n_err++;
                $display("FAIL val_cpl[%0d]: cpl=%b err=%b start=%b len=%0d expected 0100 1 0 %0d",
                         j, s_cpl_valid, s_cpl_err, o_dma_start, o_dma_total_len, v_len[j]);
            end
            step();
            n_cmp++;
            if (o_dma_start !== 1'b0 || s_cpl_valid !== 4'b0000) begin
                n_err++;
                $display("FAIL val_after[%0d]: start=%b cpl=%b expected 0 0000", j, o_dma_start, s_cpl_valid);
            end
        end
        s_req_valid = 4'b0000;
    endtask

    task automatic test_error_priority();
        set_req(1, 32'h3000_0000, 32'd16);
        s_req_valid = 4'b0010;
        #1;
        n_cmp++;
        if (s_req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL errp_ready: got %b expected 0010", s_req_ready);
        end
        step();
        s_req_valid = 4'b0000;
        step();
        i_dma_done  = 1'b1;
        i_dma_error = 1'b1;
        step();
        i_dma_done  = 1'b0;
        i_dma_error = 1'b0;
        n_cmp++;
        if (s_cpl_valid !== 4'b0010 || s_cpl_err !== 1'b1 || o_dma_abort !== 1'b0) begin
            n_err++;
            $display("FAIL errp_cpl: cpl=%b err=%b abort=%b expected 0010 1 0", s_cpl_valid, s_cpl_err, o_dma_abort);
        end
        step();
    endtask

    task automatic test_done_at_timeout();
        set_req(2, 32'h2000_0100, 32'd8);
        s_req_valid = 4'b0100;
        step();
        s_req_valid = 4'b0000;
        repeat (15) step();
        i_dma_done = 1'b1;
        step();
        i_dma_done = 1'b0;
        n_cmp++;
        if (s_cpl_valid !== 4'b0100 || s_cpl_err !== 1'b0 || o_dma_abort !== 1'b0) begin
            n_err++;
            $display("FAIL race_cpl: cpl=%b err=%b abort=%b expected 0100 0 0", s_cpl_valid, s_cpl_err, o_dma_abort);
        end
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        set_req(0, 32'h5000_0000, 32'd32);
        set_req(1, 32'h5000_1000, 32'd64);
        s_req_valid = 4'b0011;
        #1;
        n_cmp++;
        if (s_req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL tmo_ready0: got %b expected 0001", s_req_ready);
        end
        step();
        s_req_valid = 4'b0010;
        n_cmp++;
        if (o_dma_start !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_start: got %b expected 1", o_dma_start);
        end
        for (int i = 1; i < 16; i++) begin
            step();
            n_cmp++;
            if (o_dma_abort !== 1'b0 || s_cpl_valid !== 4'b0000) begin
                n_err++;
                $display("FAIL tmo_early[%0d]: abort=%b cpl=%b expected 0 0000", i, o_dma_abort, s_cpl_valid);
            end
        end
        step();
        n_cmp++;
        if (o_dma_abort !== 1'b1 || s_cpl_valid !== 4'b0001 || s_cpl_err !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_abort: abort=%b cpl=%b err=%b expected 1 0001 1", o_dma_abort, s_cpl_valid, s_cpl_err);
        end
        step();
        n_cmp++;
        if (o_dma_abort !== 1'b0 || s_req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL tmo_next: abort=%b ready=%b expected 0 0010", o_dma_abort, s_req_ready);
        end
        step();
        s_req_valid = 4'b0000;
        n_cmp++;
        if (o_dma_start !== 1'b1 || o_active_id !== 2'd1 || o_dma_base_addr !== 32'h5000_1000) begin
            n_err++;
            $display("FAIL tmo_next_start: start=%b id=%0d base=%h expected 1 1 50001000",
                     o_dma_start, o_active_id, o_dma_base_addr);
        end
        step();
        i_dma_done = 1'b1;
        step();
        i_dma_done = 1'b0;
        n_cmp++;
        if (s_cpl_valid !== 4'b0010 || s_cpl_err !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_next_cpl: cpl=%b err=%b expected 0010 0", s_cpl_valid, s_cpl_err);
        end
        step();
    endtask

    task automatic test_reset_mid_wait();
        set_req(2, 32'h2000_0100, 32'd8);
        set_req(3, 32'h6000_0000, 32'd4);
        s_req_valid = 4'b0100;
        step();
        s_req_valid = 4'b0000;
        step();
        step();
        rst_n       = 1'b0;
        s_req_valid = 4'b1010;
        #1;
        n_cmp++;
        if (s_req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL rstw_ready_in_reset: got %b expected 0000", s_req_ready);
        end
        step();
        n_cmp++;
        if ({o_busy, o_dma_start, o_dma_abort, s_cpl_err, s_cpl_valid, o_active_id} !== 10'd0
            || o_dma_base_addr !== 32'd0 || o_dma_total_len !== 32'd0) begin
            n_err++;
            $display("FAIL rstw_outputs: busy=%b start=%b abort=%b err=%b cpl=%b id=%0d base=%h len=%h expected all 0",
                     o_busy, o_dma_start, o_dma_abort, s_cpl_err, s_cpl_valid, o_active_id,
                     o_dma_base_addr, o_dma_total_len);
        end
        rst_n      = 1'b1;
        i_dma_done = 1'b1;
        #1;
        n_cmp++;
        if (s_req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL rstw_rrptr: ready=%b expected 0010", s_req_ready);
        end
        step();
        i_dma_done  = 1'b0;
        s_req_valid = 4'b0000;
        n_cmp++;
        if (s_cpl_valid !== 4'b0000 || o_dma_start !== 1'b1 || o_active_id !== 2'd1
            || o_dma_base_addr !== 32'h5000_1000) begin
            n_err++;
            $display("FAIL rstw_restart: cpl=%b start=%b id=%0d base=%h expected 0000 1 1 50001000",
                     s_cpl_valid, o_dma_start, o_active_id, o_dma_base_addr);
        end
        step();
        i_dma_done = 1'b1;
        step();
        i_dma_done = 1'b0;
        n_cmp++;
        if (s_cpl_valid !== 4'b0010 || s_cpl_err !== 1'b0) begin
            n_err++;
            $display("FAIL rstw_cpl: cpl=%b err=%b expected 0010 0", s_cpl_valid, s_cpl_err);
        end
        step();
    endtask

    initial begin
        rst_n       = 1'b0;
        s_req_valid = 4'b0000;
        s_req_addr  = '0;
        s_req_len   = '0;
        i_dma_done  = 1'b0;
        i_dma_error = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_validation();
        test_error_priority();
        test_done_at_timeout();
        test_timeout();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
